// File: rtl/wb_stage_param.sv
// wb_stage_param: MIPS write-back stage register with sub-word loads, bypass register and retire counter
module wb_stage_param #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                hold,
    input  logic                flush,
    input  logic [DATA_W-1:0]   LMD_i,
    input  logic [DATA_W-1:0]   ALUo_i,
    input  logic [31:0]         IR_i,
    output logic [DATA_W-1:0]   WB_Data,
    output logic                WB_Write,
    output logic [REG_AW-1:0]   WB_Addr,
    output logic                fwd_valid,
    output logic [REG_AW-1:0]   fwd_addr,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [RETIRE_W-1:0] retire_cnt
);
    logic [DATA_W-1:0] lmd, aluo;
    logic [31:0]       ir;
    logic              valid, fresh;
    logic [5:0]        op, funct;
    logic              is_r, is_imm, is_load, is_jal, dec_write, wr;
    logic [REG_AW-1:0] dec_addr;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_data, dec_data;
    logic              unused_ir;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign unused_ir = ^{ir[25:21], ir[10:6]};

    // decode the resident instruction into write enable, target register and write data
    always_comb begin
        is_r      = op == 6'h00;
        is_imm    = op[5:3] == 3'b001;
        is_load   = op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
        is_jal    = op == 6'h03;
        dec_write = (is_r && funct != 6'h08) || is_imm || is_load || is_jal;
        dec_addr  = is_jal ? '1 : is_r ? REG_AW'(ir[15:11]) : REG_AW'(ir[20:16]);
        byte_v    = lmd[{aluo[1:0], 3'b000} +: 8];
        half_v    = lmd[{aluo[1], 4'b0000} +: 16];
        load_data = op == 6'h20 ? DATA_W'($signed(byte_v)) :
                    op == 6'h24 ? DATA_W'(byte_v) :
                    op == 6'h21 ? DATA_W'($signed(half_v)) :
                    op == 6'h25 ? DATA_W'(half_v) :
                                  DATA_W'($signed(lmd[31:0]));
        dec_data  = is_load ? load_data : aluo;
        wr        = valid && fresh && dec_write && dec_addr != '0;
        WB_Write  = wr && !rst;
        WB_Data   = rst ? '0 : dec_data;
        WB_Addr   = rst ? '0 : dec_addr;
    end

    // falling-edge stage update: flush beats hold beats load; bypass and counter track the outgoing instruction
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            lmd        <= '0;
            aluo       <= '0;
            ir         <= '0;
            valid      <= 1'b0;
            fresh      <= 1'b0;
            fwd_valid  <= 1'b0;
            fwd_addr   <= '0;
            fwd_data   <= '0;
            retire_cnt <= '0;
        end else begin
            if (wr) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= dec_addr;
                fwd_data  <= dec_data;
            end
            if (valid && fresh)
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            if (flush) begin
                valid <= 1'b0;
                fresh <= 1'b0;
            end else if (hold) begin
                fresh <= 1'b0;
            end else begin
                lmd   <= LMD_i;
                aluo  <= ALUo_i;
                ir    <= IR_i;
                valid <= in_valid;
                fresh <= in_valid;
            end
        end
    end
endmodule
